combo_seq_gen: RTL and testbench

COMBO_SEQ_GEN -- requirements
Module: combo_seq_gen

---
 rtl/combo_seq_gen.sv | 100 ++++++++++
 tb/tb_combo_seq_gen.sv | 245 ++++++++++++++++++++++++
 2 files changed

// File: rtl/combo_seq_gen.sv
// Three-digit combination generator driven by a 16-bit Fibonacci LFSR.
// Optional macro COMBO_UNIQUE_DIGITS_EN rejects digits repeating an earlier digit of the same draw.
module combo_seq_gen (
    input  logic        clk,
    input  logic        nrst,
    input  logic        gen_req,
    input  logic        seed_load,
    input  logic [15:0] seed,
    output logic [11:0] seq,
    output logic        seq_valid,
    output logic        busy
);

    localparam logic [15:0] LFSR_INIT = 16'hACE1;

    typedef enum logic [2:0] {
        IDLE,
        DRAW0,
        DRAW1,
        DRAW2,
        DONE
    } state_t;

    state_t      state;
    logic [15:0] lfsr;
    logic [15:0] lfsr_next;
    logic [3:0]  cand;
    logic        accept;

    assign cand = lfsr[3:0];

    // A zero seed would lock the LFSR, so it falls back to the reset value.
    always_comb begin
        lfsr_next = {lfsr[14:0], lfsr[15] ^ lfsr[13] ^ lfsr[12] ^ lfsr[10]};
        if (seed_load) begin
            lfsr_next = (seed == 16'h0000) ? LFSR_INIT : seed;
        end
    end

`ifdef COMBO_UNIQUE_DIGITS_EN
    always_comb begin
        accept = 1'b1;
        case (state)
            DRAW1:   accept = (cand != seq[3:0]);
            DRAW2:   accept = (cand != seq[3:0]) && (cand != seq[7:4]);
            default: accept = 1'b1;
        endcase
    end
`else
    assign accept = 1'b1;
`endif

    always_ff @(posedge clk or negedge nrst) begin
        if (!nrst) begin
            state     <= IDLE;
            lfsr      <= LFSR_INIT;
            seq       <= '0;
            seq_valid <= 1'b0;
            busy      <= 1'b0;
        end else begin
            lfsr <= lfsr_next;
            case (state)
                IDLE, DONE: begin
                    if (gen_req) begin
                        state     <= DRAW0;
                        seq       <= '0;
                        seq_valid <= 1'b0;
                        busy      <= 1'b1;
                    end
                end
                DRAW0: begin
                    if (accept) begin
                        seq[3:0] <= cand;
                        state    <= DRAW1;
                    end
                end
                DRAW1: begin
                    if (accept) begin
                        seq[7:4] <= cand;
                        state    <= DRAW2;
                    end
                end
                DRAW2: begin
                    if (accept) begin
                        seq[11:8] <= cand;
                        state     <= DONE;
                        busy      <= 1'b0;
                        seq_valid <= 1'b1;
                    end
                end
                default: begin
                    state     <= IDLE;
                    busy      <= 1'b0;
                    seq_valid <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_combo_seq_gen.sv
// Directed bench for combo_seq_gen; a digit-counting model is compared every cycle.
// Honours COMBO_UNIQUE_DIGITS_EN the same way the design does.
module tb_combo_seq_gen;

    logic        clk;
    logic        nrst;
    logic        gen_req;
    logic        seed_load;
    logic [15:0] seed;
    logic [11:0] seq;
    logic        seq_valid;
    logic        busy;

    int checks = 0;
    int errors = 0;

    combo_seq_gen dut (
        .clk       (clk),
        .nrst      (nrst),
        .gen_req   (gen_req),
        .seed_load (seed_load),
        .seed      (seed),
        .seq       (seq),
        .seq_valid (seq_valid),
        .busy      (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Model: drawing flag, count of digits already taken, digit list.
    logic [15:0] m_lfsr;
    logic        m_active;
    int          m_n;
    logic [3:0]  m_dig [3];
    logic        m_valid;

    function automatic logic [15:0] lfsr_step(input logic [15:0] v);
        return {v[14:0], v[15] ^ v[13] ^ v[12] ^ v[10]};
    endfunction

    function automatic bit digit_ok(input logic [3:0] c, input int n,
                                    input logic [3:0] d0, input logic [3:0] d1);
        bit ok;
        ok = 1'b1;
`ifdef COMBO_UNIQUE_DIGITS_EN
        if (n >= 1 && c == d0) ok = 1'b0;
        if (n >= 2 && c == d1) ok = 1'b0;
`endif
        return ok;
    endfunction

    always @(posedge clk or negedge nrst) begin
        if (!nrst) begin
            m_lfsr   <= 16'hACE1;
            m_active <= 1'b0;
            m_n      <= 0;
            m_valid  <= 1'b0;
            m_dig[0] <= 4'h0;
            m_dig[1] <= 4'h0;
            m_dig[2] <= 4'h0;
        end else begin
            m_lfsr <= seed_load ? ((seed == 16'h0000) ? 16'hACE1 : seed) : lfsr_step(m_lfsr);
            if (!m_active) begin
                if (gen_req) begin
                    m_active <= 1'b1;
                    m_n      <= 0;
                    m_valid  <= 1'b0;
                    m_dig[0] <= 4'h0;
                    m_dig[1] <= 4'h0;
                    m_dig[2] <= 4'h0;
                end
            end else if (digit_ok(m_lfsr[3:0], m_n, m_dig[0], m_dig[1])) begin
                m_dig[m_n] <= m_lfsr[3:0];
                if (m_n == 2) begin
                    m_active <= 1'b0;
                    m_valid  <= 1'b1;
                end else begin
                    m_n <= m_n + 1;
                end
            end
        end
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    always @(negedge clk) begin
        chk("model_seq", {20'h0, seq}, {20'h0, m_dig[2], m_dig[1], m_dig[0]});
        chk("model_seq_valid", {31'h0, seq_valid}, {31'h0, m_valid});
        chk("model_busy", {31'h0, busy}, {31'h0, m_active});
    end

    task automatic cyc(input logic gr, input logic sl, input logic [15:0] sd);
        gen_req   = gr;
        seed_load = sl;
        seed      = sd;
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        nrst = 1'b0;
        cyc(1'b0, 1'b0, 16'h0);
        cyc(1'b0, 1'b0, 16'h0);
        nrst = 1'b1;
    endtask

    task automatic draw_default();
        cyc(1'b1, 1'b0, 16'h0);
        repeat (3) cyc(1'b0, 1'b0, 16'h0);
    endtask

    typedef struct {
        logic        gr;
        logic        sl;
        logic [15:0] sd;
    } vec_t;

    vec_t vecs [14];

    initial begin
        gen_req   = 1'b0;
        seed_load = 1'b0;
        seed      = 16'h0;
        nrst      = 1'b1;
        #1 nrst   = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        chk("rst_seq", {20'h0, seq}, 32'h0);
        chk("rst_seq_valid", {31'h0, seq_valid}, 32'h0);
        chk("rst_busy", {31'h0, busy}, 32'h0);
        nrst = 1'b1;

        // Basic draw from the reset LFSR value.
        cyc(1'b1, 1'b0, 16'h0);
        chk("d1_busy", {31'h0, busy}, 32'h1);
        chk("d1_valid", {31'h0, seq_valid}, 32'h0);
        chk("d1_model_lfsr", {16'h0, m_lfsr}, 32'h59C3);
        cyc(1'b0, 1'b0, 16'h0);
        chk("d2_model_lfsr", {16'h0, m_lfsr}, 32'hB387);
        cyc(1'b0, 1'b0, 16'h0);
        chk("d3_model_lfsr", {16'h0, m_lfsr}, 32'h670F);
        chk("d3_busy", {31'h0, busy}, 32'h1);
        chk("d3_valid", {31'h0, seq_valid}, 32'h0);
        cyc(1'b0, 1'b0, 16'h0);
        chk("d4_seq", {20'h0, seq}, 32'hF73);
        chk("d4_valid", {31'h0, seq_valid}, 32'h1);
        chk("d4_busy", {31'h0, busy}, 32'h0);
        repeat (3) cyc(1'b0, 1'b0, 16'h0);
        chk("done_hold_seq", {20'h0, seq}, 32'hF73);
        chk("done_hold_valid", {31'h0, seq_valid}, 32'h1);

        // gen_req held high: ignored while busy, restarts straight out of DONE.
        cyc(1'b1, 1'b0, 16'h0);
        chk("restart_seq", {20'h0, seq}, 32'h0);
        chk("restart_valid", {31'h0, seq_valid}, 32'h0);
        chk("restart_busy", {31'h0, busy}, 32'h1);
        repeat (3) cyc(1'b1, 1'b0, 16'h0);
`ifndef COMBO_UNIQUE_DIGITS_EN
        chk("held_done_valid", {31'h0, seq_valid}, 32'h1);
        chk("held_done_busy", {31'h0, busy}, 32'h0);
        cyc(1'b1, 1'b0, 16'h0);
        chk("held_restart_seq", {20'h0, seq}, 32'h0);
        chk("held_restart_valid", {31'h0, seq_valid}, 32'h0);
        chk("held_restart_busy", {31'h0, busy}, 32'h1);
`endif
        repeat (6) cyc(1'b0, 1'b0, 16'h0);

        // Seed load together with the request.
        do_reset();
        cyc(1'b1, 1'b1, 16'h800F);
        chk("seed_model_lfsr", {16'h0, m_lfsr}, 32'h800F);
        repeat (3) cyc(1'b0, 1'b0, 16'h0);
`ifdef COMBO_UNIQUE_DIGITS_EN
        chk("uniq_e4_valid", {31'h0, seq_valid}, 32'h0);
        chk("uniq_e4_busy", {31'h0, busy}, 32'h1);
        cyc(1'b0, 1'b0, 16'h0);
        chk("uniq_seq", {20'h0, seq}, 32'hCEF);
        chk("uniq_valid", {31'h0, seq_valid}, 32'h1);
`else
        chk("plain_seq", {20'h0, seq}, 32'hEFF);
        chk("plain_valid", {31'h0, seq_valid}, 32'h1);
`endif

        // Zero seed falls back to ACE1.
        do_reset();
        repeat (2) cyc(1'b0, 1'b0, 16'h0);
        cyc(1'b0, 1'b1, 16'h0000);
        chk("zero_seed_model_lfsr", {16'h0, m_lfsr}, 32'hACE1);
        draw_default();
        chk("zero_seed_seq", {20'h0, seq}, 32'hF73);
        chk("zero_seed_valid", {31'h0, seq_valid}, 32'h1);

        // Asynchronous reset in the middle of a draw.
        do_reset();
        cyc(1'b1, 1'b0, 16'h0);
        cyc(1'b0, 1'b0, 16'h0);
        chk("mid_partial_busy", {31'h0, busy}, 32'h1);
        #2 nrst = 1'b0;
        #1;
        chk("mid_rst_seq", {20'h0, seq}, 32'h0);
        chk("mid_rst_valid", {31'h0, seq_valid}, 32'h0);
        chk("mid_rst_busy", {31'h0, busy}, 32'h0);
        @(posedge clk);
        #1 nrst = 1'b1;
        cyc(1'b0, 1'b0, 16'h0);
        chk("post_rst_idle_valid", {31'h0, seq_valid}, 32'h0);
        do_reset();
        draw_default();
        chk("post_rst_seq", {20'h0, seq}, 32'hF73);
        chk("post_rst_valid", {31'h0, seq_valid}, 32'h1);

        // Mixed vectors: seed loads mid-draw, requests while busy.
        vecs[0]  = '{1'b1, 1'b0, 16'h0000};
        vecs[1]  = '{1'b1, 1'b1, 16'h1234};
        vecs[2]  = '{1'b0, 1'b0, 16'h0000};
        vecs[3]  = '{1'b1, 1'b0, 16'h0000};
        vecs[4]  = '{1'b0, 1'b0, 16'h0000};
        vecs[5]  = '{1'b0, 1'b0, 16'h0000};
        vecs[6]  = '{1'b1, 1'b1, 16'hFFFF};
        vecs[7]  = '{1'b0, 1'b1, 16'h0000};
        vecs[8]  = '{1'b0, 1'b0, 16'h0000};
        vecs[9]  = '{1'b0, 1'b1, 16'h0001};
        vecs[10] = '{1'b0, 1'b0, 16'h0000};
        vecs[11] = '{1'b0, 1'b0, 16'h0000};
        vecs[12] = '{1'b1, 1'b0, 16'h0000};
        vecs[13] = '{1'b0, 1'b0, 16'h0000};
        for (int i = 0; i < 14; i++) begin
            cyc(vecs[i].gr, vecs[i].sl, vecs[i].sd);
        end
        repeat (12) cyc(1'b0, 1'b0, 16'h0);

        @(negedge clk);
        #1;
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
